// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and types for the load/store unit
// Holds the funct3 access-size codes, the FSM state enum and the timeout counter width.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam int TMO_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane alignment for the load/store unit
// Ports: funct3/addr_lo select the access; wdata -> wdata_rep (lane replicated),
// rdata -> rdata_ext (extracted and extended), mask = byte lanes,
// illegal = unknown funct3, misaligned = fault (only with LSU_MISALIGN_TRAP_EN).
// Without LSU_MISALIGN_TRAP_EN, halfword/word accesses ignore the offending low
// address bits, which the mask and extract logic already do by construction.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        illegal,
    output logic        misaligned
);

    logic [31:0] byte_src;
    logic [15:0] half_src;

    assign byte_src = rdata >> {addr_lo, 3'b000};
    assign half_src = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // funct3[2] set means the unsigned variant, so it suppresses sign extension.
    always_comb begin
        mask      = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;
        illegal   = 1'b0;
        case (funct3)
            LSU_B, LSU_BU: begin
                mask      = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{byte_src[7] & ~funct3[2]}}, byte_src[7:0]};
            end
            LSU_H, LSU_HU: begin
                mask      = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{half_src[15] & ~funct3[2]}}, half_src};
            end
            LSU_W: begin
                mask      = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (((funct3 == LSU_H) || (funct3 == LSU_HU)) && addr_lo[0]) ||
                        ((funct3 == LSU_W) && (addr_lo != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: request/acknowledge data-memory access FSM
// Ports: i_valid/o_ready/o_busy request handshake from execute; i_wen, i_funct3,
// i_addr, i_wdata describe the access; o_dmem_* / i_dmem_ack / i_dmem_rdata form the
// memory port; o_done pulses with o_rdata (extended load data) and o_err.
// Optional macro: LSU_MISALIGN_TRAP_EN (misaligned h/w accesses fault instead of
// being silently aligned).
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_wen,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_dmem_req,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_busy
);

    // The abort fires in the BUS cycle whose count is TIMEOUT_CYCLES-1, so the
    // request is visible for exactly TIMEOUT_CYCLES cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             wen_q, wen_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        idle, in_bus;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [31:0] al_wdata;
    logic [3:0]  al_mask;
    logic [31:0] al_wdata_rep;
    logic [31:0] al_rdata_ext;
    logic        al_illegal;
    logic        al_misaligned;

    assign idle   = (state_q == ST_IDLE);
    assign in_bus = (state_q == ST_BUS);

    // In IDLE the aligner inspects the incoming request to decide on a fault;
    // afterwards it works from the captured request so bus outputs stay stable.
    assign al_funct3  = idle ? i_funct3    : funct3_q;
    assign al_addr_lo = idle ? i_addr[1:0] : addr_q[1:0];
    assign al_wdata   = idle ? i_wdata     : wdata_q;

    lsu_align u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .wdata      (al_wdata),
        .rdata      (i_dmem_rdata),
        .mask       (al_mask),
        .wdata_rep  (al_wdata_rep),
        .rdata_ext  (al_rdata_ext),
        .illegal    (al_illegal),
        .misaligned (al_misaligned)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    addr_d   = i_addr;
                    funct3_d = i_funct3;
                    wen_d    = i_wen;
                    wdata_d  = i_wdata;
                    cnt_d    = '0;
                    rdata_d  = 32'h0;
                    if (al_illegal || al_misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                // Ack is tested first so an ack in the expiry cycle still completes.
                if (i_dmem_ack) begin
                    rdata_d = wen_q ? 32'h0 : al_rdata_ext;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
            wen_q    <= 1'b0;
            wdata_q  <= 32'h0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign o_ready      = idle;
    assign o_busy       = !idle;
    assign o_dmem_req   = in_bus;
    assign o_dmem_wen   = in_bus & wen_q;
    assign o_dmem_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
    assign o_dmem_mask  = in_bus ? al_mask : 4'b0000;
    assign o_dmem_wdata = in_bus ? al_wdata_rep : 32'h0;
    assign o_done       = (state_q == ST_RESP);
    assign o_err        = o_done & err_q;
    assign o_rdata      = o_done ? rdata_q : 32'h0;

endmodule
